// File: rtl/fpu_normalizer.sv
// fpu_normalizer
// Post-arithmetic normalize/round stage for single-precision results.
// Takes a raw sign / wide exponent / wide mantissa from the FPU datapath.
// Normalizes the mantissa one bit position per cycle, rounds to nearest-even,
// then saturates to infinity or flushes to zero where needed. It presents the
// finished IEEE 754 word behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock (rising edge) and async active-low reset
//   in_valid / in_ready    input handshake; in_ready is high only when idle
//   in_sign                result sign
//   in_exponent [9:0]      signed biased exponent (127 = 2^0)
//   in_mantissa [MW-1:0]   value = in_mantissa / 2^(MW-2) * 2^(in_exponent-127)
//   out_valid / out_ready  output handshake
//   outp [31:0]            IEEE 754 single-precision result
//   overflow               result saturated to infinity
//   underflow              result flushed to zero
module fpu_normalizer #(
    parameter int MW = 48,
    parameter int EW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [9:0]    in_exponent,
    input  logic [MW-1:0] in_mantissa,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   outp,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [1:0] {IDLE, NORM, RND, DONE} state_t;

    // Bits below the guard bit (mant[MW-27:0]); empty when MW == 26.
    localparam logic [MW-1:0]        LOW_MASK = {MW{1'b1}} >> 26;
    localparam logic signed [EW-1:0] EXP_INF  = EW'(255);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    state_t state;
    state_t next_state;

    logic                 sign;
    logic signed [EW-1:0] exponent;
    logic [MW-1:0]        mant;
    logic                 sticky;

    logic                 mant_zero;
    logic                 norm_done;

    logic [22:0]          frac;
    logic                 guard;
    logic                 sticky_all;
    logic                 round_up;
    logic [23:0]          frac_sum;
    logic signed [EW-1:0] exp_rnd;
    logic [31:0]          rnd_outp;
    logic                 rnd_ovf;
    logic                 rnd_unf;

    // Normalization is complete when the mantissa is zero, or when the leading
    // one sits exactly at the hidden-one position MW-2.
    assign mant_zero = (mant == '0);
    assign norm_done = mant_zero || (!mant[MW-1] && mant[MW-2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = NORM;
            NORM: if (norm_done) next_state = RND;
            RND:  next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Round to nearest-even on the normalized mantissa. A carry out of the
    // 23-bit fraction means the mantissa reached 2.0. That value is exactly
    // representable as fraction 0 with the exponent bumped by one.
    always_comb begin
        frac       = mant[MW-3:MW-25];
        guard      = mant[MW-26];
        sticky_all = (|(mant & LOW_MASK)) | sticky;
        round_up   = guard && (sticky_all || frac[0]);
        frac_sum   = {1'b0, frac} + {23'b0, round_up};
        exp_rnd    = exponent + {{(EW-1){1'b0}}, frac_sum[23]};
        rnd_outp   = {sign, exp_rnd[7:0], frac_sum[22:0]};
        rnd_ovf    = 1'b0;
        rnd_unf    = 1'b0;
        if (mant_zero) begin
            rnd_outp = {sign, 31'b0};
        end else if (exp_rnd >= EXP_INF) begin
            rnd_outp = {sign, 8'hFF, 23'b0};
            rnd_ovf  = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
            rnd_outp = {sign, 31'b0};
            rnd_unf  = 1'b1;
        end
    end

    // Datapath registers. Inputs are captured only at acceptance. In NORM
    // the register moves one bit per cycle. Results are updated only on the
    // RND->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            exponent  <= '0;
            mant      <= '0;
            sticky    <= 1'b0;
            outp      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign     <= in_sign;
                        exponent <= {{(EW-10){in_exponent[9]}}, in_exponent};
                        mant     <= in_mantissa;
                        sticky   <= 1'b0;
                    end
                end
                NORM: begin
                    if (!mant_zero) begin
                        if (mant[MW-1]) begin
                            mant     <= {1'b0, mant[MW-1:1]};
                            exponent <= exponent + EW'(1);
                            sticky   <= sticky | mant[0];
                        end else if (!mant[MW-2]) begin
                            mant     <= {mant[MW-2:0], 1'b0};
                            exponent <= exponent - EW'(1);
                        end
                    end
                end
                RND: begin
                    outp      <= rnd_outp;
                    overflow  <= rnd_ovf;
                    underflow <= rnd_unf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fpu_normalizer.md
Name: fpu_normalizer

Overview:
- Multi-cycle post-arithmetic stage sitting directly downstream of the FPU datapath.
- Accepts a raw sign / wide exponent / wide mantissa result (unnormalized sum, difference or 24x24 product).
- Normalizes it one bit-shift per cycle, rounds to nearest-even, handles zero/overflow/underflow, and emits an IEEE 754 single-precision word over a valid/ready handshake.

Parameters:
- MW, 48, input mantissa width; hidden-one target position is bit MW-2 (bit MW-1 is carry/product overflow); MW >= 26.
- EW, 12, internal signed exponent width; wide enough that shifts never wrap.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  raw result present
- in_ready  output  1  block can accept (high only in IDLE)
- in_sign  input  1  result sign
- in_exponent  input  10  signed two's-complement biased exponent (127 = 2^0)
- in_mantissa  input  MW  value = in_mantissa / 2^(MW-2) * 2^(in_exponent-127)
- out_valid  output  1  outp holds a finished result
- out_ready  input  1  consumer takes result
- outp  output  32  IEEE 754 single: [31] sign, [30:23] exponent, [22:0] fraction
- overflow  output  1  result saturated to infinity
- underflow  output  1  result flushed to zero

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=1; out_valid=0; outp=0; overflow=0; underflow=0; internal regs cleared. Reset mid-operation discards the item in flight, with no output produced.
- States: IDLE, NORM, RND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture sign, sign-extend exponent to EW bits, capture mantissa, clear sticky, go to NORM.
- NORM (one action per cycle, priority order):
  - mantissa==0 -> RND.
  - bit MW-1 set -> shift right 1, exponent+1, sticky |= shifted-out bit, stay in NORM.
  - bit MW-2 clear -> shift left 1, exponent-1, stay in NORM.
  - otherwise -> RND.
- RND (single cycle): computes outp, overflow and underflow; registers them; sets out_valid=1; goes to DONE.
  - Fraction f = mant[MW-3:MW-25]; guard g = mant[MW-26]; sticky s = OR(mant[MW-27:0]) | sticky.
  - Round up when g && (s || f[0]).
  - A round-up carry out of f sets f=0 and exponent+1.
  - Zero mantissa -> outp={sign,31'b0}; no flags.
  - Rounded exponent >= 255 -> outp={sign,8'hFF,23'b0}; overflow=1.
  - Rounded exponent <= 0 -> outp={sign,31'b0}; underflow=1. No denormals are produced.
  - Otherwise outp={sign, exponent[7:0], f}.
- DONE: outputs held stable while out_ready=0. On out_ready: out_valid=0, go to IDLE; in_ready rises the next cycle. No bypass: a new input is never accepted in the same cycle as out_ready.
- Latency from the acceptance edge to out_valid high:
  - 2 cycles if already normalized or zero.
  - +1 cycle per shift.
  - Worst case MW cycles (left shifts); right-shift path at most 3 cycles.
- Flags and outp change only on the RND->DONE edge and on reset.
- in_ready and out_valid are never both high.
- Input fields are sampled only at acceptance; changes on them while busy are ignored.

Test Plan:
- Normalized: sign=0, exp=127, mant=1<<46 -> outp=0x3F800000, no flags, out_valid exactly 2 cycles after accept.
- Carry/left shift:
  - mant=3<<46, exp=127 -> 0x40400000 at latency 3.
  - mant=1<<40, exp=133 -> 0x3F800000 at latency 8.
- Rounding:
  - exp=127, mant=(1<<46)|(1<<22) (tie, LSB 0) -> 0x3F800000.
  - mant=(1<<46)|(1<<23)|(1<<22) (tie, LSB 1) -> 0x3F800002.
  - mant=(1<<47)|1, exp=127 -> right-shift sticky only, no round -> 0x40000000.
- Limits:
  - exp=254, mant=1<<47 -> 0x7F800000, overflow=1.
  - sign=1, exp=0, mant=1<<46 -> 0x80000000, underflow=1.
  - sign=1, mant=0 -> 0x80000000, no flags.
- Handshake: hold out_ready=0 for 5 cycles after out_valid -> outp stable, in_ready=0, second in_valid not accepted; raise out_ready -> out_valid drops next edge, in_ready=1 the cycle after, second item then completes correctly.
- Reset: assert rst_n=0 asynchronously during NORM of the mant=1<<40 case -> outputs immediately 0, in_ready=1; no out_valid after release; next input processes normally.
